// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2**ADDR_W_DEF;
  localparam int ZERO_REG   = 0;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the request at index ptr has highest priority,
// followed by ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] iso;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    iso   = rot & ((~rot) + NUM_REQ'(1));
    grant = NUM_REQ'(({iso, iso} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter with pending-register scoreboard.
// Define REGFILE_WB_RR_EN for round-robin arbitration; otherwise fixed priority.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqRg,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        Grant,
  input  logic                      IssueValid,
  input  logic [ADDR_W-1:0]         IssueRg,
  output logic [ADDR_W-1:0]         WriteRg,
  output logic                      RegWrite,
  output logic [DATA_W-1:0]         WriteData,
  output logic [2**ADDR_W-1:0]      Pending
);

  localparam int                PTR_W    = ptr_width(NUM_REQ);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [PTR_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 xfer;
  logic [ADDR_W-1:0]    sel_rg;
  logic [DATA_W-1:0]    sel_data;
  logic [2**ADDR_W-1:0] pend_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (Req),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  assign Grant = Reset ? arb_grant : '0;
  assign xfer  = |Grant;

  always_comb begin
    sel_rg   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Grant[i]) begin
        sel_rg   = ReqRg[i*ADDR_W +: ADDR_W];
        sel_data = ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_WB_RR_EN
  logic [PTR_W-1:0] next_ptr;

  always_comb begin
    next_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Grant[i]) next_ptr = (i == NUM_REQ-1) ? '0 : PTR_W'(i+1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) ptr <= '0;
    else if (xfer) ptr <= next_ptr;
  end
`else
  assign ptr = '0;
`endif

  // Clear on write-back first so a same-cycle issue to that register wins.
  always_comb begin
    pend_next = Pending;
    if (xfer && (sel_rg != ZERO_IDX)) pend_next[sel_rg] = 1'b0;
    if (IssueValid && (IssueRg != ZERO_IDX)) pend_next[IssueRg] = 1'b1;
    pend_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      RegWrite  <= 1'b0;
      WriteRg   <= '0;
      WriteData <= '0;
      Pending   <= '0;
    end else begin
      RegWrite <= xfer && (sel_rg != ZERO_IDX);
      if (xfer) begin
        WriteRg   <= sel_rg;
        WriteData <= sel_data;
      end
      Pending <= pend_next;
    end
  end

endmodule
